cpu_out_capture_fifo: RTL and testbench

//  Downstream consumer of the CPU output port (outFlag/out). Captures every 25-bit word

---
 rtl/cpu_out_capture_fifo.sv | 99 +++++++++
 tb/tb_cpu_out_capture_fifo.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_out_capture_fifo.sv
// rtl/cpu_out_capture_fifo.sv - capture FIFO for the CPU output port with valid/ready drain
//
// Ports:
//   clock        rising-edge clock, shared with the CPU
//   reset        asynchronous active-low reset, release synchronous to clock
//   in_flag      CPU outFlag; in_data is captured when set
//   in_data      CPU output word
//   out_valid    oldest word is presented on out_data
//   out_data     oldest buffered word, zero when empty (first-word-fall-through)
//   out_ready    consumer accepts out_data this cycle
//   level        number of words held, 0..DEPTH
//   full         level == DEPTH
//   overflow     sticky flag: a word was dropped since reset or clear_stats
//   drop_count   saturating count of dropped words
//   clear_stats  synchronous clear of overflow and drop_count
module cpu_out_capture_fifo #(
    parameter int DATAWIDTH = 25,
    parameter int DEPTH     = 8,
    parameter int ADDRW     = 3,
    parameter int DROPW     = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_flag,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    output logic [DATAWIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic [ADDRW:0]       level,
    output logic                 full,
    output logic                 overflow,
    output logic [DROPW-1:0]     drop_count,
    input  logic                 clear_stats
);

    localparam logic [ADDRW:0] FULL_LEVEL = (ADDRW + 1)'(DEPTH);

    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [ADDRW-1:0]     wr_ptr;
    logic [ADDRW-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;
    logic                 drop;

    // Status is derived from level so it tracks the async reset immediately.
    assign out_valid = (level != '0);
    assign full      = (level == FULL_LEVEL);

    // A full FIFO still accepts a word when the oldest one leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = in_flag && (!full || pop);
    assign drop = in_flag && full && !pop;

    // Gating by out_valid keeps stale or uninitialised storage off the bus.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    // Storage is deliberately not reset; only written words are ever presented.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is natural overflow.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // Clear takes priority over a drop in the same cycle.
            if (clear_stats) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_out_capture_fifo.sv
// tb/tb_cpu_out_capture_fifo.sv - scoreboard bench for cpu_out_capture_fifo
module tb_cpu_out_capture_fifo;

    localparam int DW    = 25;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DROPW = 8;
    localparam int DMAX  = (1 << DROPW) - 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_flag;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_ready;
    logic [AW:0]     level;
    logic            full;
    logic            overflow;
    logic [DROPW-1:0] drop_count;
    logic            clear_stats;

    cpu_out_capture_fifo #(
        .DATAWIDTH(DW), .DEPTH(DEPTH), .ADDRW(AW), .DROPW(DROPW)
    ) dut (
        .clock(clock), .reset(reset), .in_flag(in_flag), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .level(level), .full(full), .overflow(overflow),
        .drop_count(drop_count), .clear_stats(clear_stats)
    );

    always #5 clock = ~clock;

    // Reference model: expected FIFO contents as a queue plus statistics.
    logic [DW-1:0] sb[$];
    int            exp_drops;
    bit            exp_ovf;
    bit            mon_en;
    int            vectors;
    int            miscompares;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented word and status mid-cycle, and retires the
    // expected word when the consumer takes it at the coming edge.
    always @(negedge clock) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("out_data", 32'(out_data), (sb.size() != 0) ? 32'(sb[0]) : 32'd0);
            chk("level", 32'(level), 32'(sb.size()));
            chk("full", 32'(full), 32'(sb.size() == DEPTH));
            chk("overflow", 32'(overflow), 32'(exp_ovf));
            chk("drop_count", 32'(drop_count), 32'(exp_drops));
            if (out_ready && sb.size() != 0) begin
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; the model is advanced just after the edge.
    task automatic step(input bit flag, input logic [DW-1:0] data, input bit rdy, input bit clr);
        bit dropped;
        in_flag     = flag;
        in_data     = flag ? data : 'x;
        out_ready   = rdy;
        clear_stats = clr;
        @(posedge clock);
        #1;
        dropped = 1'b0;
        if (flag) begin
            if (sb.size() < DEPTH) sb.push_back(data);
            else dropped = 1'b1;
        end
        if (clr) begin
            exp_ovf   = 1'b0;
            exp_drops = 0;
        end else if (dropped) begin
            exp_ovf = 1'b1;
            if (exp_drops != DMAX) exp_drops++;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_drops = 0;
        exp_ovf   = 1'b0;
    endtask

    task automatic drain();
        while (sb.size() != 0) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b0; in_flag = 1'b0; in_data = '0; out_ready = 1'b0; clear_stats = 1'b0;
        mon_en = 1'b0; vectors = 0; miscompares = 0;
        model_reset();

        // T1: reset held, in_flag toggling
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_flag = ~in_flag;
            in_data = DW'(i + 7);
            @(negedge clock);
            chk("rst_valid", 32'(out_valid), 32'd0);
            chk("rst_level", 32'(level), 32'd0);
            chk("rst_drops", 32'(drop_count), 32'd0);
            chk("rst_ovf", 32'(overflow), 32'd0);
            chk("rst_data", 32'(out_data), 32'd0);
        end
        @(posedge clock);
        #1;
        in_flag = 1'b0;
        reset   = 1'b1;
        mon_en  = 1'b1;

        // T2: ordering
        step(1'b1, 25'h0000001, 1'b0, 1'b0);
        step(1'b1, 25'h0000002, 1'b0, 1'b0);
        step(1'b1, 25'h1FFFFFF, 1'b0, 1'b0);
        drain();

        // Empty with simultaneous flag and ready: push only
        step(1'b1, 25'h0ABCDEF, 1'b1, 1'b0);
        drain();

        // T3: overflow then clear
        for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
        chk("t3_drops", 32'(drop_count), 32'd2);
        drain();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);

        // T4: full with push and pop together, across pointer wrap
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(32'h200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, DW'(32'h300 + i), 1'b1, 1'b0);
        chk("t4_level", 32'(level), 32'(DEPTH));
        drain();

        // T5: saturation, then clear racing a drop
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        chk("t5_sat", 32'(drop_count), 32'(DMAX));
        step(1'b1, DW'($urandom), 1'b0, 1'b1);
        chk("t5_clear_wins", 32'(drop_count), 32'd0);
        drain();

        // T6: async reset between edges with 5 words held
        for (int i = 0; i < 5; i++) step(1'b1, DW'(32'h400 + i), 1'b0, 1'b0);
        in_flag = 1'b0;
        mon_en  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
        step(1'b1, 25'h0155555, 1'b0, 1'b0);
        drain();

        // Randomised traffic with varying producer/consumer rates
        for (int i = 0; i < 3000; i++) begin
            int fp;
            int rp;
            fp = (i / 500) % 3 == 0 ? 80 : 40;
            rp = (i / 500) % 2 == 0 ? 30 : 75;
            step($urandom_range(99) < fp, DW'($urandom), $urandom_range(99) < rp,
                 $urandom_range(99) < 2);
        end
        drain();

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
